bus_sync_fifo: RTL and testbench
================================

# bus_sync_fifo

Synchronous valid/ready FIFO placed directly downstream of `bus_ready_delay`. It absorbs bursts from that register slice and decouples it from a consumer whose ready toggles every cycle. Data leaves in arrival order with a registered, show-ahead output. There is no combinational path from `ready_i` to `ready_o`.

## Interface
- `Width`, 32: data word width in bits.
- `Depth`, 8: number of storage entries. Must be a power of two and at least 2.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `valid_i`  input  1  upstream word valid.
- `data_i`  input  Width  upstream word.
- `ready_o`  output  1  FIFO can accept a word this cycle.
- `valid_o`  output  1  head word available on `data_o`.
- `data_o`  output  Width  head word (show-ahead).
- `ready_i`  input  1  downstream accepts head word.
- `count_o`  output  $clog2(Depth)+1  number of stored words.

## Operation
- Push: the FIFO accepts a word when `valid_i && ready_o` at a rising edge. The word is written at `wr_ptr`, and `wr_ptr` increments.
- Pop: the head word is consumed when `valid_o && ready_i` at a rising edge, and `rd_ptr` increments.
- Pointers are $clog2(Depth)+1 bits wide. The MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2·Depth, with no special handling at wrap.
- `ready_o = !full`. This is a registered-state decode that does not depend on `ready_i`. When full, a push is refused even if a pop occurs in the same cycle.
- `valid_o = !empty`, and `data_o = mem[rd_ptr[low bits]]`.
- `count_o = wr_ptr - rd_ptr`, taken modulo 2^(ptr width). Range is 0..Depth.
- Simultaneous push and pop (neither empty nor full): `count_o` is unchanged and both pointers advance.
- Push into empty with `ready_i=1`: the word is not popped in the same cycle. There is no bypass.
- Order is strict FIFO. Words are never dropped or duplicated.
- `data_i` is ignored when `valid_i=0`. `ready_i` is ignored when `valid_o=0`.
- Memory contents are not reset. Only the pointers are reset.

## Timing
- Reset values, in the cycle after a rising edge with `rst=1`:
  - `wr_ptr=0`, `rd_ptr=0`
  - `valid_o=0`, `ready_o=1`, `count_o=0`
  - `data_o` is don't-care
- Reset mid-operation: all stored words are discarded on that edge. Handshakes presented in the reset cycle have no effect.
- Latency: a word pushed at edge N appears on `valid_o`/`data_o` after edge N and can be popped at edge N+1 at the earliest. Minimum latency is 1 cycle.
- Full to not-full: a pop at edge N raises `ready_o` after edge N, so a push can occur at edge N+1.
- Throughput is 1 word per cycle when neither empty nor full.
- Outputs `valid_o`, `ready_o` and `count_o` depend only on flops.
- `data_o` is a memory read mux driven by the registered `rd_ptr`.

## Test plan
- Reset: hold `rst=1` for 3 cycles with `valid_i=1`. Required: after release, `count_o=0`, `valid_o=0`, `ready_o=1`, and no word is stored.
- Fill then drain, with Depth=8 and `ready_i=0`:
  - Push 0x0..0x8 back-to-back.
  - Required: 0x0..0x7 are accepted; `ready_o=0` after the 8th push; 0x8 is held upstream; `count_o=8`.
  - Then set `ready_i=1`. Required: `data_o` sequence is 0x0..0x8 in order, and `count_o` returns to 0.
- Push into empty with `ready_i=1` held: push 0xA5. Required: `valid_o` rises one cycle later with `data_o=0xA5`, it pops on the next edge, and `count_o` goes 0→1→0.
- Full with simultaneous pop: at `count_o=8`, drive `valid_i=1` and `ready_i=1`. Required: the pop occurs and the push is refused that edge; `count_o=7`; the push is accepted on the following edge; `count_o=8`.
- Throttled consumer:
  - Upstream streams 0x0..0xC continuously. `ready_i` is 1 for 6 cycles, then alternates 0/1.
  - Required: all 13 words arrive in order without loss or duplication. Scoreboard check.
  - `count_o` never exceeds 8. `ready_o` never depends combinationally on `ready_i`.
- Pointer wrap: perform 40 push/pop pairs at 1 word per cycle (more than 2·Depth). Required: order and `count_o` stay correct across wrap, and the full and empty flags never assert falsely.

Source files
------------

// File: rtl/bus_sync_fifo.sv
// Show-ahead valid/ready FIFO with wrap-bit pointers.
// ready_o and valid_o come from pointer flops only.
module bus_sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic [Width-1:0]         data_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [Width-1:0]         data_o,
  input  logic                     ready_i,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign ready_o = !full;
  assign valid_o = !empty;
  assign data_o  = mem[rd_ptr[AW-1:0]];
  assign count_o = wr_ptr - rd_ptr;

  assign push = valid_i && !full;
  assign pop  = !empty && ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is never reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: tb/tb_bus_sync_fifo.sv
// Directed bench for bus_sync_fifo with a queue scoreboard.
// Each tick checks flags, count and head data against the model.
module tb_bus_sync_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        ready_i;
  logic [3:0]  count_o;

  logic [31:0] sb[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;

  bus_sync_fifo #(.Width(32), .Depth(8)) dut (
    .clk(clk),
    .rst(rst),
    .valid_i(valid_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .data_o(data_o),
    .ready_i(ready_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(output bit pushed);
    bit exp_rdy;
    bit exp_vld;
    logic [31:0] exp_d;
    @(negedge clk);
    exp_rdy = (sb.size() < 8);
    exp_vld = (sb.size() != 0);
    chk("ready_o", 32'(ready_o), 32'(exp_rdy));
    chk("valid_o", 32'(valid_o), 32'(exp_vld));
    chk("count_o", 32'(count_o), 32'(sb.size()));
    ready_i = !ready_i;
    #1;
    chk("ready_o_vs_ready_i", 32'(ready_o), 32'(exp_rdy));
    ready_i = !ready_i;
    if (exp_vld && ready_i) begin
      exp_d = sb.pop_front();
      chk("data_o", data_o, exp_d);
      pops++;
    end
    pushed = valid_i && exp_rdy;
    if (pushed) sb.push_back(data_i);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit p;
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick(p);
    tick(p);
    chk("drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit p;
    int next;
    int cyc;
    int start;

    // reset with valid_i held high
    rst = 1'b1;
    valid_i = 1'b1;
    data_i = 32'hDEAD;
    ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    valid_i = 1'b0;
    sb.delete();
    tick(p);

    // fill then drain, 0x8 held upstream
    ready_i = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      valid_i = 1'b1;
      data_i = 32'(i);
      tick(p);
    end
    chk("full_count", 32'(count_o), 32'd8);
    chk("full_ready", 32'(ready_o), 32'd0);
    ready_i = 1'b1;
    tick(p);
    tick(p);
    valid_i = 1'b0;
    drain();

    // push into empty with ready_i held
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i = 32'hA5;
    tick(p);
    valid_i = 1'b0;
    chk("a5_count1", 32'(count_o), 32'd1);
    chk("a5_data", data_o, 32'hA5);
    tick(p);
    tick(p);

    // full with simultaneous pop
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1;
      data_i = 32'h100 + 32'(i);
      tick(p);
    end
    data_i = 32'h1FF;
    ready_i = 1'b1;
    tick(p);
    chk("fullpop_refused", 32'(p), 32'd0);
    ready_i = 1'b0;
    chk("fullpop_count7", 32'(count_o), 32'd7);
    tick(p);
    chk("fullpop_accepted", 32'(p), 32'd1);
    valid_i = 1'b0;
    chk("fullpop_count8", 32'(count_o), 32'd8);
    drain();

    // throttled consumer
    next = 0;
    start = pops;
    for (cyc = 0; cyc < 80 && (pops - start) < 13; cyc++) begin
      valid_i = (next < 13);
      data_i = 32'h300 + 32'(next);
      ready_i = (cyc < 6) ? 1'b1 : cyc[0];
      tick(p);
      if (p) next++;
    end
    chk("throttle_pops", 32'(pops - start), 32'd13);
    drain();

    // pointer wrap: 40 words at one per cycle
    start = pops;
    ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      valid_i = 1'b1;
      data_i = 32'h400 + 32'(i);
      tick(p);
    end
    drain();
    chk("wrap_pops", 32'(pops - start), 32'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
